// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the datapath.
// The master side is the sequencer: it reads the instruction and the branch
// flag and drives every datapath strobe. The slave side is the datapath.
interface control_sequencer_if;
    // Datapath -> sequencer
    logic        stop;
    logic [31:0] IR_Data;
    logic        con_output;

    // Register load strobes
    logic        PC_enable;
    logic        PC_increment_enable;
    logic        IR_enable;
    logic        Y_enable;
    logic        Z_enable;
    logic        MAR_enable;
    logic        MDR_enable;
    logic        r_enable;
    logic        con_enable;
    logic        LO_enable;
    logic        HI_enable;

    // Memory strobes
    logic        read;
    logic        write;

    // Register-file select/encode controls
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        ba_select;

    // Bus source selects (one-hot or all zero)
    logic        PC_select;
    logic        Z_LO_select;
    logic        Z_HI_select;
    logic        MDR_select;
    logic        c_select;
    logic        r_select;
    logic        LO_select;
    logic        HI_select;

    // ALU opcode and run indicator
    logic [4:0]  alu_instruction;
    logic        run;

    modport master (
        input  stop, IR_Data, con_output,
        output PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
               MAR_enable, MDR_enable, r_enable, con_enable, LO_enable, HI_enable,
               read, write, Gra, Grb, Grc, ba_select,
               PC_select, Z_LO_select, Z_HI_select, MDR_select, c_select,
               r_select, LO_select, HI_select, alu_instruction, run
    );

    modport slave (
        output stop, IR_Data, con_output,
        input  PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
               MAR_enable, MDR_enable, r_enable, con_enable, LO_enable, HI_enable,
               read, write, Gra, Grb, Grc, ba_select,
               PC_select, Z_LO_select, Z_HI_select, MDR_select, c_select,
               r_select, LO_select, HI_select, alu_instruction, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit. Walks fetch T0-T2, then an opcode-specific execute
// sequence T3..Tn, then returns to fetch (or HALT when stop is pending).
// Outputs are a Moore decode of the current step and the opcode captured at
// the end of T2; the only exception is the branch commit in T6, which looks
// at con_output directly during that cycle.
module control_sequencer #(
    parameter logic [4:0] ALU_ADD = 5'b00001,
    parameter logic [4:0] ALU_SUB = 5'b00010,
    parameter logic [4:0] ALU_AND = 5'b00011,
    parameter logic [4:0] ALU_OR  = 5'b00100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    control_sequencer_if.master  bus
);

    // Sequencer steps
    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;

    // Instruction classes; opcodes sharing an execute sequence share a class
    localparam logic [3:0] K_NOP  = 4'd0;
    localparam logic [3:0] K_LD   = 4'd1;
    localparam logic [3:0] K_LDI  = 4'd2;
    localparam logic [3:0] K_ST   = 4'd3;
    localparam logic [3:0] K_RALU = 4'd4;
    localparam logic [3:0] K_IALU = 4'd5;
    localparam logic [3:0] K_BR   = 4'd6;
    localparam logic [3:0] K_JR   = 4'd7;
    localparam logic [3:0] K_MFHI = 4'd8;
    localparam logic [3:0] K_MFLO = 4'd9;
    localparam logic [3:0] K_HALT = 4'd10;

    logic [3:0] state_q, state_d;
    logic [4:0] opcode_q, opcode_d;
    logic [3:0] cls;
    logic [3:0] last_st;
    logic [4:0] alu_op;

    // Step register and opcode latch; reset aborts any instruction at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_RESET;
            opcode_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Opcode is captured as fetch finishes and held through execute
    always_comb begin
        opcode_d = (state_q == S_T2) ? bus.IR_Data[31:27] : opcode_q;
    end

    // Map the held opcode to its execute class and ALU operation
    always_comb begin
        cls    = K_NOP;
        alu_op = ALU_ADD;
        case (opcode_q)
            5'b00000: cls = K_LD;
            5'b00001: cls = K_LDI;
            5'b00010: cls = K_ST;
            5'b00011: begin cls = K_RALU; alu_op = ALU_ADD; end
            5'b00100: begin cls = K_RALU; alu_op = ALU_SUB; end
            5'b00101: begin cls = K_RALU; alu_op = ALU_AND; end
            5'b00110: begin cls = K_RALU; alu_op = ALU_OR;  end
            5'b01100: begin cls = K_IALU; alu_op = ALU_ADD; end
            5'b01101: begin cls = K_IALU; alu_op = ALU_AND; end
            5'b01110: begin cls = K_IALU; alu_op = ALU_OR;  end
            5'b10010: cls = K_BR;
            5'b10100: cls = K_JR;
            5'b11000: cls = K_MFHI;
            5'b11001: cls = K_MFLO;
            5'b11011: cls = K_HALT;
            default:  cls = K_NOP;   // nop and every unassigned opcode
        endcase
    end

    // Final execute step of each class; stop is only honoured there
    always_comb begin
        case (cls)
            K_LD, K_ST:     last_st = S_T7;
            K_BR:           last_st = S_T6;
            K_LDI, K_RALU,
            K_IALU:         last_st = S_T5;
            default:        last_st = S_T3;
        endcase
    end

    // Step sequencing: linear through fetch, then to T0/HALT at the last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (cls == K_HALT) begin
                    state_d = S_HALT;
                end else if (state_q == last_st) begin
                    state_d = bus.stop ? S_HALT : S_T0;
                end else begin
                    state_d = state_q + 4'd1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // Strobe decode; everything defaults low so RESET and HALT drive all zeros
    always_comb begin
        bus.PC_enable           = 1'b0;
        bus.PC_increment_enable = 1'b0;
        bus.IR_enable           = 1'b0;
        bus.Y_enable            = 1'b0;
        bus.Z_enable            = 1'b0;
        bus.MAR_enable          = 1'b0;
        bus.MDR_enable          = 1'b0;
        bus.r_enable            = 1'b0;
        bus.con_enable          = 1'b0;
        bus.LO_enable           = 1'b0;
        bus.HI_enable           = 1'b0;
        bus.read                = 1'b0;
        bus.write               = 1'b0;
        bus.Gra                 = 1'b0;
        bus.Grb                 = 1'b0;
        bus.Grc                 = 1'b0;
        bus.ba_select           = 1'b0;
        bus.PC_select           = 1'b0;
        bus.Z_LO_select         = 1'b0;
        bus.Z_HI_select         = 1'b0;
        bus.MDR_select          = 1'b0;
        bus.c_select            = 1'b0;
        bus.r_select            = 1'b0;
        bus.LO_select           = 1'b0;
        bus.HI_select           = 1'b0;
        bus.alu_instruction     = 5'd0;
        bus.run                 = (state_q != S_RESET) && (state_q != S_HALT);

        case (state_q)
            S_T0: begin
                bus.PC_select  = 1'b1;
                bus.MAR_enable = 1'b1;
            end
            S_T1: begin
                bus.PC_increment_enable = 1'b1;
                bus.read                = 1'b1;
                bus.MDR_enable          = 1'b1;
            end
            S_T2: begin
                bus.MDR_select = 1'b1;
                bus.IR_enable  = 1'b1;
            end
            S_T3: begin
                case (cls)
                    K_LD, K_LDI, K_ST: begin
                        bus.Grb       = 1'b1;
                        bus.ba_select = 1'b1;
                        bus.Y_enable  = 1'b1;
                    end
                    K_RALU, K_IALU: begin
                        bus.Grb      = 1'b1;
                        bus.r_select = 1'b1;
                        bus.Y_enable = 1'b1;
                    end
                    K_BR: begin
                        bus.Gra        = 1'b1;
                        bus.r_select   = 1'b1;
                        bus.con_enable = 1'b1;
                    end
                    K_JR: begin
                        bus.Gra       = 1'b1;
                        bus.r_select  = 1'b1;
                        bus.PC_enable = 1'b1;
                    end
                    K_MFLO: begin
                        bus.LO_select = 1'b1;
                        bus.Gra       = 1'b1;
                        bus.r_enable  = 1'b1;
                    end
                    K_MFHI: begin
                        bus.HI_select = 1'b1;
                        bus.Gra       = 1'b1;
                        bus.r_enable  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    K_LD, K_LDI, K_ST: begin
                        bus.c_select        = 1'b1;
                        bus.alu_instruction = ALU_ADD;
                        bus.Z_enable        = 1'b1;
                    end
                    K_RALU: begin
                        bus.Grc             = 1'b1;
                        bus.r_select        = 1'b1;
                        bus.alu_instruction = alu_op;
                        bus.Z_enable        = 1'b1;
                    end
                    K_IALU: begin
                        bus.c_select        = 1'b1;
                        bus.alu_instruction = alu_op;
                        bus.Z_enable        = 1'b1;
                    end
                    K_BR: begin
                        bus.PC_select = 1'b1;
                        bus.Y_enable  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    K_LDI, K_RALU, K_IALU: begin
                        bus.Z_LO_select = 1'b1;
                        bus.Gra         = 1'b1;
                        bus.r_enable    = 1'b1;
                    end
                    K_LD, K_ST: begin
                        bus.Z_LO_select = 1'b1;
                        bus.MAR_enable  = 1'b1;
                    end
                    K_BR: begin
                        bus.c_select        = 1'b1;
                        bus.alu_instruction = ALU_ADD;
                        bus.Z_enable        = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    K_LD: begin
                        bus.read       = 1'b1;
                        bus.MDR_enable = 1'b1;
                    end
                    K_ST: begin
                        // MDR loads from the register bus, not memory
                        bus.Gra        = 1'b1;
                        bus.r_select   = 1'b1;
                        bus.MDR_enable = 1'b1;
                    end
                    K_BR: begin
                        // Branch target in Z is committed only when taken
                        if (bus.con_output) begin
                            bus.Z_LO_select = 1'b1;
                            bus.PC_enable   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    K_LD: begin
                        bus.MDR_select = 1'b1;
                        bus.Gra        = 1'b1;
                        bus.r_enable   = 1'b1;
                    end
                    K_ST: begin
                        bus.write = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a cycle-by-cycle table of expected strobe
// vectors for a program of instructions, plus hand sequences for asynchronous
// reset, reset abort mid-instruction and the halt opcode.
module tb_control_sequencer;

    logic clk;
    logic reset_n;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of every output, MSB first
    logic [30:0] obs;
    assign obs = {bus.PC_enable, bus.PC_increment_enable, bus.IR_enable,
                  bus.Y_enable, bus.Z_enable, bus.MAR_enable, bus.MDR_enable,
                  bus.r_enable, bus.con_enable, bus.LO_enable, bus.HI_enable,
                  bus.read, bus.write, bus.Gra, bus.Grb, bus.Grc, bus.ba_select,
                  bus.PC_select, bus.Z_LO_select, bus.Z_HI_select,
                  bus.MDR_select, bus.c_select, bus.r_select, bus.LO_select,
                  bus.HI_select, bus.alu_instruction, bus.run};

    localparam logic [30:0] PCEN  = 31'(1) << 30;
    localparam logic [30:0] PCINC = 31'(1) << 29;
    localparam logic [30:0] IREN  = 31'(1) << 28;
    localparam logic [30:0] YEN   = 31'(1) << 27;
    localparam logic [30:0] ZEN   = 31'(1) << 26;
    localparam logic [30:0] MAREN = 31'(1) << 25;
    localparam logic [30:0] MDREN = 31'(1) << 24;
    localparam logic [30:0] REN   = 31'(1) << 23;
    localparam logic [30:0] CONEN = 31'(1) << 22;
    localparam logic [30:0] RD    = 31'(1) << 19;
    localparam logic [30:0] WR    = 31'(1) << 18;
    localparam logic [30:0] GRA   = 31'(1) << 17;
    localparam logic [30:0] GRB   = 31'(1) << 16;
    localparam logic [30:0] GRC   = 31'(1) << 15;
    localparam logic [30:0] BA    = 31'(1) << 14;
    localparam logic [30:0] PCSEL = 31'(1) << 13;
    localparam logic [30:0] ZLO   = 31'(1) << 12;
    localparam logic [30:0] MDRS  = 31'(1) << 10;
    localparam logic [30:0] CSEL  = 31'(1) << 9;
    localparam logic [30:0] RSEL  = 31'(1) << 8;
    localparam logic [30:0] LOSEL = 31'(1) << 7;
    localparam logic [30:0] HISEL = 31'(1) << 6;
    localparam logic [30:0] RUN   = 31'(1);
    localparam logic [30:0] A_ADD = 31'(5'b00001) << 1;
    localparam logic [30:0] A_SUB = 31'(5'b00010) << 1;
    localparam logic [30:0] A_AND = 31'(5'b00011) << 1;
    localparam logic [30:0] A_OR  = 31'(5'b00100) << 1;

    localparam logic [30:0] T0V = RUN | PCSEL | MAREN;
    localparam logic [30:0] T1V = RUN | PCINC | RD | MDREN;
    localparam logic [30:0] T2V = RUN | MDRS | IREN;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        stop;
        logic [30:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   passed;
    int   total;

    function automatic logic [31:0] op(input logic [4:0] o);
        return {o, 27'd0};
    endfunction

    task automatic add(input logic [31:0] ir, input logic con, input logic stop,
                       input logic [30:0] exp);
        vec_t v;
        v.ir = ir; v.con = con; v.stop = stop; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic fetch(input logic [31:0] ir);
        add(ir, 1'b0, 1'b0, T0V);
        add(ir, 1'b0, 1'b0, T1V);
        add(ir, 1'b0, 1'b0, T2V);
    endtask

    task automatic chk(input string nm, input logic [30:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", nm, obs, exp);
        else
            passed++;
    endtask

    task automatic step_chk(input string nm, input logic [30:0] exp);
        @(negedge clk);
        #1;
        chk(nm, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d)", passed, total);
        $fatal(1);
    end

    initial begin
        logic [31:0] ir;
        passed = 0;
        total  = 0;
        reset_n        = 1'b0;
        bus.stop       = 1'b0;
        bus.IR_Data    = 32'd0;
        bus.con_output = 1'b0;

        // ldi r2, r0, 0x65
        ir = 32'h09000065;
        fetch(ir);
        add(ir, 0, 0, RUN | GRB | BA | YEN);
        add(ir, 0, 0, RUN | CSEL | A_ADD | ZEN);
        add(ir, 0, 0, RUN | ZLO | GRA | REN);
        // mflo
        ir = op(5'b11001);
        fetch(ir);
        add(ir, 0, 0, RUN | LOSEL | GRA | REN);
        // st
        ir = op(5'b00010);
        fetch(ir);
        add(ir, 0, 0, RUN | GRB | BA | YEN);
        add(ir, 0, 0, RUN | CSEL | A_ADD | ZEN);
        add(ir, 0, 0, RUN | ZLO | MAREN);
        add(ir, 0, 0, RUN | GRA | RSEL | MDREN);
        add(ir, 0, 0, RUN | WR);
        // br not taken, then taken
        for (int t = 0; t < 2; t++) begin
            ir = op(5'b10010);
            fetch(ir);
            add(ir, 1'(t), 0, RUN | GRA | RSEL | CONEN);
            add(ir, 1'(t), 0, RUN | PCSEL | YEN);
            add(ir, 1'(t), 0, RUN | CSEL | A_ADD | ZEN);
            add(ir, 1'(t), 0, (t == 1) ? (RUN | ZLO | PCEN) : RUN);
        end
        // ld
        ir = op(5'b00000);
        fetch(ir);
        add(ir, 0, 0, RUN | GRB | BA | YEN);
        add(ir, 0, 0, RUN | CSEL | A_ADD | ZEN);
        add(ir, 0, 0, RUN | ZLO | MAREN);
        add(ir, 0, 0, RUN | RD | MDREN);
        add(ir, 0, 0, RUN | MDRS | GRA | REN);
        // add
        ir = op(5'b00011);
        fetch(ir);
        add(ir, 0, 0, RUN | GRB | RSEL | YEN);
        add(ir, 0, 0, RUN | GRC | RSEL | A_ADD | ZEN);
        add(ir, 0, 0, RUN | ZLO | GRA | REN);
        // andi
        ir = op(5'b01101);
        fetch(ir);
        add(ir, 0, 0, RUN | GRB | RSEL | YEN);
        add(ir, 0, 0, RUN | CSEL | A_AND | ZEN);
        add(ir, 0, 0, RUN | ZLO | GRA | REN);
        // or
        ir = op(5'b00110);
        fetch(ir);
        add(ir, 0, 0, RUN | GRB | RSEL | YEN);
        add(ir, 0, 0, RUN | GRC | RSEL | A_OR | ZEN);
        add(ir, 0, 0, RUN | ZLO | GRA | REN);
        // jr
        ir = op(5'b10100);
        fetch(ir);
        add(ir, 0, 0, RUN | GRA | RSEL | PCEN);
        // illegal opcode runs as nop
        ir = op(5'b11111);
        fetch(ir);
        add(ir, 0, 0, RUN);
        // mfhi
        ir = op(5'b11000);
        fetch(ir);
        add(ir, 0, 0, RUN | HISEL | GRA | REN);
        // sub with stop raised in T4: completes write-back then halts
        ir = op(5'b00100);
        fetch(ir);
        add(ir, 0, 0, RUN | GRB | RSEL | YEN);
        add(ir, 0, 1, RUN | GRC | RSEL | A_SUB | ZEN);
        add(ir, 0, 1, RUN | ZLO | GRA | REN);
        add(ir, 0, 1, 31'd0);
        add(ir, 0, 0, 31'd0);
        add(ir, 0, 0, 31'd0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 31'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            bus.IR_Data    = tbl[i].ir;
            bus.con_output = tbl[i].con;
            bus.stop       = tbl[i].stop;
            #1;
            chk($sformatf("vec[%0d]", i), tbl[i].exp);
        end

        // Asynchronous reset asserted mid-cycle, then release to T0
        bus.stop = 1'b0;
        bus.IR_Data = op(5'b00000);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 31'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step_chk("release_T0", T0V);
        step_chk("ld_T1", T1V);
        step_chk("ld_T2", T2V);
        step_chk("ld_T3", RUN | GRB | BA | YEN);
        step_chk("ld_T4", RUN | CSEL | A_ADD | ZEN);

        // Reset during ld aborts without any further strobes
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_ld", 31'd0);
        @(posedge clk);
        #1;
        chk("abort_hold", 31'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.IR_Data = op(5'b11011);

        // halt opcode: HALT holds until reset
        step_chk("halt_T0", T0V);
        step_chk("halt_T1", T1V);
        step_chk("halt_T2", T2V);
        step_chk("halt_T3", RUN);
        for (int k = 0; k < 4; k++)
            step_chk($sformatf("halt_hold%0d", k), 31'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("halt_reset", 31'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.IR_Data = op(5'b11010);
        step_chk("halt_exit_T0", T0V);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit directly upstream of the datapath.
- Each clock it drives every datapath enable, select, memory and ALU-opcode strobe. Bench FSMs currently drive these signals by hand.
- It sequences fetch (T0–T2), then an opcode-specific execute sequence, then returns to fetch.
- It consumes `IR_Data` and `con_output` from the datapath.

Parameters:
- `ALU_ADD`, 5'b00001, ALU opcode for add
- `ALU_SUB`, 5'b00010, ALU opcode for subtract
- `ALU_AND`, 5'b00011, ALU opcode for and
- `ALU_OR`, 5'b00100, ALU opcode for or

Ports:
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `stop` input 1: level; halt at the next instruction boundary.
- `IR_Data` input 32: instruction register contents; opcode is `IR_Data[31:27]`.
- `con_output` input 1: branch-condition flip-flop output.
- `PC_enable`, `PC_increment_enable`, `IR_enable`, `Y_enable`, `Z_enable`, `MAR_enable`, `MDR_enable`, `r_enable`, `con_enable`, `LO_enable`, `HI_enable` output 1 each: register load strobes.
- `read`, `write` output 1 each: memory strobes.
- `Gra`, `Grb`, `Grc`, `ba_select` output 1 each: select/encode controls.
- `PC_select`, `Z_LO_select`, `Z_HI_select`, `MDR_select`, `c_select`, `r_select`, `LO_select`, `HI_select` output 1 each: bus source selects.
- `alu_instruction` output 5: ALU opcode.
- `run` output 1: high while executing, low in RESET/HALT.

Behaviour:
- **Clocking and reset:** one state per clock.
  - Outputs are a Moore decode of state plus registered opcode, held for the full cycle; the datapath latches at the closing rising edge.
  - `reset_n` low: state=RESET asynchronously.
  - In RESET every output is 0, including `alu_instruction=0` and `run=0`.
  - First edge after release: RESET→T0.
  - Reset mid-instruction aborts immediately; there are no partial writes after the reset edge.
- **Opcode capture:** opcode is latched from `IR_Data[31:27]` at the end of T2 and used for T3 onward.
- **Bus select rule:** at most one bus select is high per state; unlisted outputs are 0.
- **Fetch:**
  - T0: `PC_select`, `MAR_enable`.
  - T1: `PC_increment_enable`, `read`, `MDR_enable`.
  - T2: `MDR_select`, `IR_enable`.
- **Opcode table:**
  - 00000 ld
  - 00001 ldi
  - 00010 st
  - 00011 add
  - 00100 sub
  - 00101 and
  - 00110 or
  - 01100 addi
  - 01101 andi
  - 01110 ori
  - 10010 br
  - 10100 jr
  - 11000 mfhi
  - 11001 mflo
  - 11010 nop
  - 11011 halt
  - Any other opcode executes as nop.
- **ldi:**
  - T3: `Grb`, `ba_select`, `Y_enable`.
  - T4: `c_select`, `ALU_ADD`, `Z_enable`.
  - T5: `Z_LO_select`, `Gra`, `r_enable`.
- **ld:**
  - T3–T4 as ldi.
  - T5: `Z_LO_select`, `MAR_enable`.
  - T6: `read`, `MDR_enable`.
  - T7: `MDR_select`, `Gra`, `r_enable`.
- **st:**
  - T3–T5 as ld.
  - T6: `Gra`, `r_select`, `MDR_enable` with `read`=0.
  - T7: `write`.
- **R-ALU (add/sub/and/or):**
  - T3: `Grb`, `r_select`, `Y_enable`.
  - T4: `Grc`, `r_select`, op code, `Z_enable`.
  - T5: `Z_LO_select`, `Gra`, `r_enable`.
- **I-ALU (addi/andi/ori):** as R-ALU, except T4 uses `c_select` instead of `Grc`/`r_select`.
- **br:**
  - T3: `Gra`, `r_select`, `con_enable`.
  - T4: `PC_select`, `Y_enable`.
  - T5: `c_select`, `ALU_ADD`, `Z_enable`.
  - T6: if `con_output`=1 then `Z_LO_select`, `PC_enable`; otherwise no strobes. `con_output` is sampled in T6.
- **jr:** T3: `Gra`, `r_select`, `PC_enable`.
- **mflo:** T3: `LO_select`, `Gra`, `r_enable`.
- **mfhi:** T3: `HI_select`, `Gra`, `r_enable`.
- **nop:** T3 with no strobes.
- **Last-state transition:** from the last state of each sequence, go to T0 if `stop`=0, else HALT.
- **halt:** T3→HALT. HALT: all outputs 0, `run`=0; the only exit is `reset_n`.
- **stop:** `stop` is sampled only at the last state of an instruction. An instruction in progress always completes; `stop` never truncates it.
- **Instruction lengths (cycles, including fetch):**
  - ldi / R-ALU / I-ALU: 6
  - ld / st / br: 8 / 8 / 7
  - jr / mflo / mfhi / nop: 4

Test Plan:
1. **Reset:** `reset_n`=0 asynchronously mid-cycle → all outputs 0, `run`=0; release → T0 next edge with `PC_select`=`MAR_enable`=1, `run`=1.
2. **ldi:** `IR_Data`=32'h09000065 (ldi, ra=2, rb=0, C=0x65) → T4 shows `alu_instruction`=00001 with `c_select`; T5 `Gra`&`r_enable`; T0 reasserted 6 cycles after the prior T0.
3. **mflo:** `IR_Data` opcode 11001 → T3 `LO_select`=`Gra`=`r_enable`=1 and all other outputs 0; next T0 4 cycles after the prior T0.
4. **st:** opcode 00010 → T6 `MDR_enable`=1 with `read`=0; T7 `write`=1 for exactly one cycle; 8-cycle instruction.
5. **br:** opcode 10010 run twice, with `con_output`=0 then 1 → T6 `PC_enable`=0 then 1; both 7 cycles.
6. **halt/stop and illegal opcode:**
   - `stop` raised during T4 of sub → sub completes (T5 write-back), then HALT with `run`=0.
   - Opcode 11111 → 4-cycle nop.
   - Opcode 11011 → HALT held until `reset_n` pulses.
